ram_bus_bridge: RTL and testbench

- Downstream neighbour of the request unit: replaces the direct single-port RAM hookup with a Wishbone-classic master port, so instruction and data traffic can reach off-core memory with multi-cycle latency.
- Accepts one request (ramaddr/ramstore/Wen/Ren) at a time.
- Drives busy back to the request unit (today tied to 0) until the bus transaction retires.
- Returns read data on rdata.

---
 rtl/bridge_pkg.sv | 15 +
 rtl/bridge_wdt.sv | 31 +++
 rtl/ram_bus_bridge.sv | 94 +++++++++
 tb/tb_ram_bus_bridge.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bridge_pkg.sv
// rtl/bridge_pkg.sv - shared state encoding and constants for the RAM-to-Wishbone bridge
package bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } bridge_state_t;

    // Low address bits forced on the bus; byte selection travels on sel only.
    localparam logic [1:0] WORD_ALIGN_MASK = 2'b00;

    localparam int DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/bridge_wdt.sv
// rtl/bridge_wdt.sv - bus-cycle watchdog; expires once run has been high for TIMEOUT_CYCLES cycles
module bridge_wdt
    import bridge_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic nrst,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt;

    // cnt holds the number of completed BUS cycles, so the current one is cnt+1
    assign expired = run && (cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (run && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ram_bus_bridge.sv
// rtl/ram_bus_bridge.sv - single-outstanding request port to Wishbone-classic master; BRIDGE_TIMEOUT_EN adds a watchdog
module ram_bus_bridge
    import bridge_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wen,
    input  logic              ren,
    input  logic [3:0]        sel,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              bus_err,
    output logic [ADDR_W-1:0] wb_adr_o,
    output logic [DATA_W-1:0] wb_dat_o,
    output logic [3:0]        wb_sel_o,
    output logic              wb_we_o,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    input  logic [DATA_W-1:0] wb_dat_i,
    input  logic              wb_ack_i,
    input  logic              wb_err_i
);

    bridge_state_t state;
    logic          timeout_hit;

    // The request unit retires the access on the DONE edge, so busy drops only there.
    assign busy     = (wen | ren) && (state != DONE);
    assign wb_stb_o = wb_cyc_o;

`ifdef BRIDGE_TIMEOUT_EN
    bridge_wdt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdt (
        .clk    (clk),
        .nrst   (nrst),
        .clear  (state != BUS),
        .run    (state == BUS),
        .expired(timeout_hit)
    );
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= IDLE;
            rdata    <= '0;
            bus_err  <= 1'b0;
            wb_adr_o <= '0;
            wb_dat_o <= '0;
            wb_sel_o <= '0;
            wb_we_o  <= 1'b0;
            wb_cyc_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (wen | ren) begin
                        wb_adr_o <= {addr[ADDR_W-1:2], addr[1:0] & WORD_ALIGN_MASK};
                        wb_dat_o <= wdata;
                        wb_sel_o <= sel;
                        wb_we_o  <= wen;
                        wb_cyc_o <= 1'b1;
                        state    <= BUS;
                    end
                end
                BUS: begin
                    // Error (or watchdog) terminates the cycle even if ack arrives alongside it.
                    if (wb_err_i || timeout_hit) begin
                        if (!wb_we_o) rdata <= '0;
                        bus_err  <= 1'b1;
                        wb_cyc_o <= 1'b0;
                        state    <= DONE;
                    end else if (wb_ack_i) begin
                        if (!wb_we_o) rdata <= wb_dat_i;
                        wb_cyc_o <= 1'b0;
                        state    <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_bus_bridge.sv
// tb/tb_ram_bus_bridge.sv - randomized self-checking bench for ram_bus_bridge against a transaction-level model
module tb_ram_bus_bridge;

`ifdef BRIDGE_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 255;
`endif

    logic        clk = 1'b0;
    logic        nrst;
    logic [31:0] addr, wdata, rdata, wb_adr_o, wb_dat_o, wb_dat_i;
    logic        wen, ren, busy, bus_err, wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i, wb_err_i;
    logic [3:0]  sel, wb_sel_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_rdata   = 32'h0;
    logic        exp_bus_err = 1'b0;

    ram_bus_bridge #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .nrst(nrst), .addr(addr), .wdata(wdata), .wen(wen), .ren(ren), .sel(sel),
        .rdata(rdata), .busy(busy), .bus_err(bus_err),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
        .wb_err_i(wb_err_i)
    );

    always #5 clk = ~clk;

    // One full access: request, `waits` stall cycles, termination, DONE, one idle cycle.
    task automatic do_txn(input logic [31:0] a, input logic [31:0] d, input bit w, input bit r,
                          input logic [3:0] s, input int waits, input bit e,
                          input logic [31:0] sd, input string name);
        @(negedge clk);
        addr = a; wdata = d; wen = w; ren = r; sel = s;
        #1;
        checks++;
        if (busy !== 1'b1 || wb_cyc_o !== 1'b0) begin
            errors++;
            $display("FAIL %s req_cycle busy=%b cyc=%b required busy=1 cyc=0", name, busy, wb_cyc_o);
        end
        for (int k = 0; k <= waits; k++) begin
            @(negedge clk);
            if (k > 0) begin
                addr = a ^ 32'h0000_0100; wdata = ~d; sel = ~s;
            end
            wb_ack_i = (k == waits) && !e;
            wb_err_i = (k == waits) && e;
            wb_dat_i = (k == waits) ? sd : $urandom;
            #1;
            checks++;
            if (wb_cyc_o !== 1'b1 || wb_stb_o !== 1'b1 || wb_adr_o !== {a[31:2], 2'b00} ||
                wb_we_o !== w || wb_sel_o !== s || wb_dat_o !== d || busy !== 1'b1) begin
                errors++;
                $display("FAIL %s bus_cycle%0d cyc=%b stb=%b adr=%h we=%b sel=%h dat=%h busy=%b required cyc=1 stb=1 adr=%h we=%b sel=%h dat=%h busy=1",
                         name, k, wb_cyc_o, wb_stb_o, wb_adr_o, wb_we_o, wb_sel_o, wb_dat_o, busy,
                         {a[31:2], 2'b00}, w, s, d);
            end
        end
        @(negedge clk);
        wb_ack_i = 1'b0; wb_err_i = 1'b0;
        if (!w) exp_rdata = e ? 32'h0 : sd;
        if (e) exp_bus_err = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0) begin
            errors++;
            $display("FAIL %s done_cycle busy=%b cyc=%b stb=%b required 0 0 0", name, busy, wb_cyc_o, wb_stb_o);
        end
        checks++;
        if (rdata !== exp_rdata || bus_err !== exp_bus_err) begin
            errors++;
            $display("FAIL %s result rdata=%h bus_err=%b required rdata=%h bus_err=%b",
                     name, rdata, bus_err, exp_rdata, exp_bus_err);
        end
        wen = 1'b0; ren = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (wb_cyc_o !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_after cyc=%b busy=%b required 0 0", name, wb_cyc_o, busy);
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (wb_adr_o !== 0 || wb_dat_o !== 0 || wb_sel_o !== 0 || wb_we_o !== 0 || wb_cyc_o !== 0 ||
            wb_stb_o !== 0 || rdata !== 0 || bus_err !== 0 || busy !== 0) begin
            errors++;
            $display("FAIL reset_outputs adr=%h dat=%h sel=%h we=%b cyc=%b stb=%b rdata=%h err=%b busy=%b required all 0",
                     wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, rdata, bus_err, busy);
        end
        ren = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_busy_comb busy=%b required 1", busy);
        end
        ren = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
    endtask

    task automatic test_read_fast();
        do_txn(32'h0000_0104, 32'h0, 1'b0, 1'b1, 4'hF, 0, 1'b0, 32'hDEAD_BEEF, "read_fast");
    endtask

    task automatic test_write_wait();
        do_txn(32'h0000_0200, 32'h1234_5678, 1'b1, 1'b0, 4'h3, 3, 1'b0, 32'hFFFF_0000, "write_wait3");
    endtask

    task automatic test_input_change();
        logic [31:0] y;
        do_txn(32'h0000_0200, 32'hA5A5_0001, 1'b1, 1'b0, 4'hF, 2, 1'b0, 32'h0, "input_change");
        // Request held through DONE into IDLE must start a second access.
        y = $urandom;
        @(negedge clk);
        addr = 32'h0000_0043; ren = 1'b1; wen = 1'b0; sel = 4'hF;
        @(negedge clk);
        wb_ack_i = 1'b1; wb_dat_i = 32'h1111_2222;
        @(negedge clk);
        wb_ack_i = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || rdata !== 32'h1111_2222) begin
            errors++;
            $display("FAIL persist_first busy=%b rdata=%h required busy=0 rdata=11112222", busy, rdata);
        end
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || wb_cyc_o !== 1'b0) begin
            errors++;
            $display("FAIL persist_idle busy=%b cyc=%b required busy=1 cyc=0", busy, wb_cyc_o);
        end
        @(negedge clk);
        wb_ack_i = 1'b1; wb_dat_i = y;
        #1;
        checks++;
        if (wb_cyc_o !== 1'b1 || wb_adr_o !== 32'h0000_0040) begin
            errors++;
            $display("FAIL persist_reissue cyc=%b adr=%h required cyc=1 adr=00000040", wb_cyc_o, wb_adr_o);
        end
        @(negedge clk);
        wb_ack_i = 1'b0; ren = 1'b0;
        exp_rdata = y;
        #1;
        checks++;
        if (rdata !== exp_rdata) begin
            errors++;
            $display("FAIL persist_second rdata=%h required %h", rdata, exp_rdata);
        end
    endtask

    task automatic test_error();
        do_txn(32'h0000_0010, 32'h0, 1'b0, 1'b1, 4'hF, 1, 1'b1, 32'h7777_7777, "err_read");
        do_txn(32'h0000_0014, 32'h0, 1'b0, 1'b1, 4'hF, 0, 1'b0, 32'hCAFE_F00D, "err_sticky_read");
        do_txn(32'h0000_0018, 32'h5555_AAAA, 1'b1, 1'b0, 4'hC, 2, 1'b0, 32'h0, "err_sticky_write");
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            logic [1:0] kind;
            kind = 2'($urandom_range(1, 3));
            do_txn($urandom, $urandom, kind[0], kind[1], 4'($urandom), $urandom_range(0, 3),
                   ($urandom_range(0, 7) == 0), $urandom, "random");
        end
    endtask

    task automatic test_timeout();
        int hi;
        hi = 0;
        @(negedge clk);
        addr = 32'h0000_0800; ren = 1'b1; wen = 1'b0; sel = 4'hF;
        wb_ack_i = 1'b0; wb_err_i = 1'b0;
`ifdef BRIDGE_TIMEOUT_EN
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (wb_cyc_o !== 1'b1) break;
            hi++;
        end
        exp_rdata = 32'h0; exp_bus_err = 1'b1;
        checks++;
        if (hi != TO || busy !== 1'b0 || rdata !== 32'h0 || bus_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout bus_cycles=%0d busy=%b rdata=%h bus_err=%b required %0d 0 00000000 1",
                     hi, busy, rdata, bus_err, TO);
        end
        ren = 1'b0;
        @(negedge clk);
`else
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            #1;
            if (wb_cyc_o === 1'b1 && busy === 1'b1) hi++;
        end
        checks++;
        if (hi != 120) begin
            errors++;
            $display("FAIL no_timeout stalled_cycles=%0d required 120", hi);
        end
        #2 nrst = 1'b0;
        ren = 1'b0;
        exp_rdata = 32'h0; exp_bus_err = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
`endif
    endtask

    task automatic test_reset_mid_bus();
        @(negedge clk);
        addr = 32'h0000_0080; wdata = 32'h0BAD_F00D; wen = 1'b1; ren = 1'b0; sel = 4'hF;
        @(negedge clk);
        #1;
        checks++;
        if (wb_cyc_o !== 1'b1 || wb_we_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_pre cyc=%b we=%b required 1 1", wb_cyc_o, wb_we_o);
        end
        #1 nrst = 1'b0;
        #1;
        exp_rdata = 32'h0; exp_bus_err = 1'b0;
        checks++;
        if (wb_cyc_o !== 0 || wb_stb_o !== 0 || wb_we_o !== 0 || wb_adr_o !== 0 || rdata !== 0 || bus_err !== 0) begin
            errors++;
            $display("FAIL rst_mid_async cyc=%b stb=%b we=%b adr=%h rdata=%h err=%b required all 0",
                     wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, rdata, bus_err);
        end
        wen = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        do_txn(32'h0000_0088, 32'h0, 1'b0, 1'b1, 4'hF, 1, 1'b0, 32'h600D_DA7A, "after_reset_read");
    endtask

    initial begin
        nrst = 1'b0;
        addr = '0; wdata = '0; wen = 1'b0; ren = 1'b0; sel = '0;
        wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
        test_reset();
        test_read_fast();
        test_write_wait();
        test_input_change();
        test_error();
        test_random();
        test_timeout();
        test_reset_mid_bus();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
